// File: rtl/ram_1p_bw.sv
// ---------------------------------------------------------------------------
// ram_1p_bw -- single-port SRAM behavioural model with byte write mask,
// 1- or 2-cycle read latency, read-valid strobe, held read data and a
// hardware clear engine that zero-fills the whole array after reset or
// on a clr_i pulse.
//
// Optional build macro: RAM_1P_PARITY_EN
//   Stores one even-parity bit per byte, adds the par_err_o output and
//   the force_bitflip() task used to corrupt the array in simulation.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   clr_i      one-cycle pulse, starts a full-array zero-fill
//   cen_i      chip enable, low active
//   oen_i      output enable, low active; high drives data_o to Z
//   wen_i      write enable, low active; high with cen_i low is a read
//   bwen_i     per-byte write enable, low active
//   addr_i     word address
//   data_i     write data
//   data_o     read data (held between reads)
//   rd_vld_o   one-cycle strobe when data_o carries a new read result
//   busy_o     high while the clear engine runs
//   acc_err_o  one-cycle pulse after an access arrived while busy
//   par_err_o  (parity build only) per-byte parity mismatch, aligned
//              with rd_vld_o
// ---------------------------------------------------------------------------
module ram_1p_bw #(
   parameter int Word_Width = 32,
   parameter int Addr_Width = 8,
   parameter int Rd_Lat     = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_i,
   input  logic                    cen_i,
   input  logic                    oen_i,
   input  logic                    wen_i,
   input  logic [Word_Width/8-1:0] bwen_i,
   input  logic [Addr_Width-1:0]   addr_i,
   input  logic [Word_Width-1:0]   data_i,
`ifdef RAM_1P_PARITY_EN
   output logic [Word_Width/8-1:0] par_err_o,
`endif
   output logic [Word_Width-1:0]   data_o,
   output logic                    rd_vld_o,
   output logic                    busy_o,
   output logic                    acc_err_o
);

   localparam int Depth = 1 << Addr_Width;
   localparam int Nb    = Word_Width / 8;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   logic [0:0]            state_q;
   logic [Addr_Width-1:0] cnt_q;

   logic [Word_Width-1:0] mem [Depth];

   logic rd_en;
   logic wr_en;
   logic clr_wr;

   // NOTE: every signal assigned in always_comb gets a value on every path
   // (here unconditionally), so no latch can be inferred.
   always_comb begin
      busy_o = (state_q == ST_CLEAR);
      rd_en  = rst_n && !busy_o && !cen_i &&  wen_i;
      wr_en  = rst_n && !busy_o && !cen_i && !wen_i;
      clr_wr = rst_n &&  busy_o;
   end

   // Clear engine. The access in a READY cycle that carries clr_i is still
   // performed; the clear starts on the following cycle.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         cnt_q     <= '0;
         acc_err_o <= 1'b0;
      end else begin
         acc_err_o <= busy_o && !cen_i;
         case (state_q)
            ST_CLEAR: begin
               if (clr_i) begin
                  cnt_q <= '0;
               end else begin
                  if (&cnt_q) state_q <= ST_READY;
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_READY: begin
               if (clr_i) begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= ST_CLEAR;
               cnt_q   <= '0;
            end
         endcase
      end
   end

`ifdef RAM_1P_PARITY_EN
   logic [Nb-1:0]         mem_par [Depth];
   logic [Addr_Width-1:0] flip_addr;
   int                    flip_bit;
   logic                  flip_tgl;
   logic                  flip_seen;

   // Simulation hook: request a single-bit flip applied on the next edge.
   // A toggle handshake keeps the array written from one process only.
   task automatic force_bitflip(input logic [Addr_Width-1:0] addr, input int bit_idx);
      flip_addr = addr;
      flip_bit  = bit_idx;
      flip_tgl  = (flip_tgl === 1'b1) ? 1'b0 : 1'b1;
   endtask

   always_ff @(posedge clk) begin
      if (!rst_n) flip_seen <= 1'b0;
      else        flip_seen <= flip_tgl;
   end
`endif

   // NOTE: the array itself has no reset; the clear engine zero-fills it,
   // which is how a real macro behaves and keeps the reset fan-out small.
   always_ff @(posedge clk) begin
      if (clr_wr) begin
         mem[cnt_q] <= '0;
`ifdef RAM_1P_PARITY_EN
         mem_par[cnt_q] <= '0;
`endif
      end else if (wr_en) begin
         for (int k = 0; k < Nb; k++) begin
            if (!bwen_i[k]) begin
               mem[addr_i][8*k +: 8] <= data_i[8*k +: 8];
`ifdef RAM_1P_PARITY_EN
               mem_par[addr_i][k] <= ^data_i[8*k +: 8];
`endif
            end
         end
      end
`ifdef RAM_1P_PARITY_EN
      if (rst_n && (flip_tgl != flip_seen))
         mem[flip_addr][flip_bit] <= ~mem[flip_addr][flip_bit];
`endif
   end

   // First read stage: captures the array before any write of this edge.
   logic [Word_Width-1:0] rd1_data;
   logic                  rd1_vld;
   logic [Word_Width-1:0] out_data;
   logic                  out_vld;
`ifdef RAM_1P_PARITY_EN
   logic [Nb-1:0]         rd1_perr;
   logic [Nb-1:0]         out_perr;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd1_data <= '0;
         rd1_vld  <= 1'b0;
`ifdef RAM_1P_PARITY_EN
         rd1_perr <= '0;
`endif
      end else begin
         rd1_vld <= rd_en;
         if (rd_en) begin
            rd1_data <= mem[addr_i];
`ifdef RAM_1P_PARITY_EN
            for (int k = 0; k < Nb; k++)
               rd1_perr[k] <= (^mem[addr_i][8*k +: 8]) ^ mem_par[addr_i][k];
`endif
         end
      end
   end

   generate
      if (Rd_Lat == 2) begin : g_lat2
         logic [Word_Width-1:0] rd2_data;
         logic                  rd2_vld;
`ifdef RAM_1P_PARITY_EN
         logic [Nb-1:0]         rd2_perr;
`endif
         // The second stage only loads on a valid result so data_o holds.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rd2_data <= '0;
               rd2_vld  <= 1'b0;
`ifdef RAM_1P_PARITY_EN
               rd2_perr <= '0;
`endif
            end else begin
               rd2_vld <= rd1_vld;
               if (rd1_vld) begin
                  rd2_data <= rd1_data;
`ifdef RAM_1P_PARITY_EN
                  rd2_perr <= rd1_perr;
`endif
               end
            end
         end
         assign out_data = rd2_data;
         assign out_vld  = rd2_vld;
`ifdef RAM_1P_PARITY_EN
         assign out_perr = rd2_vld ? rd2_perr : '0;
`endif
      end else begin : g_lat1
         assign out_data = rd1_data;
         assign out_vld  = rd1_vld;
`ifdef RAM_1P_PARITY_EN
         assign out_perr = rd1_vld ? rd1_perr : '0;
`endif
      end
   endgenerate

   // Output enable only gates the pad; the pipeline is unaffected.
   assign data_o   = oen_i ? {Word_Width{1'bz}} : out_data;
   assign rd_vld_o = out_vld;
`ifdef RAM_1P_PARITY_EN
   assign par_err_o = out_perr;
`endif

endmodule
